// File: rtl/cal_seg_display.sv
// Binary-to-seven-segment display stage: a sequential double-dabble converter
// feeding six registered active-low digits, with leading-zero blanking and overflow dashes.
module cal_seg_display #(
  parameter int IN_W          = 21,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [IN_W-1:0] value,
  input  logic            load,
  output logic [6:0]      seg0,
  output logic [6:0]      seg1,
  output logic [6:0]      seg2,
  output logic [6:0]      seg3,
  output logic [6:0]      seg4,
  output logic [6:0]      seg5,
  output logic            busy,
  output logic            done,
  output logic            overflow,
  output logic [1:0]      dbg_state_o
);
  // load is a one-cycle strobe with no ready: it is always accepted, either
  // starting a conversion (IDLE) or overwriting the pending value (busy).

  localparam int CNT_W = $clog2(IN_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

  state_t            state_q, state_d;
  logic [IN_W-1:0]   bin_q, bin_d;
  logic [23:0]       bcd_q, bcd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              pend_q, pend_d;
  logic [IN_W-1:0]   pend_val_q, pend_val_d;
  logic [41:0]       seg_q, seg_d;
  logic              ovf_out_q, ovf_out_d;
  logic              done_q, done_d;

  logic [23:0]       bcd_adj;
  logic [41:0]       seg_next;
  logic              lead;

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 7'b1000000;
      4'd1:    enc = 7'b1111001;
      4'd2:    enc = 7'b0100100;
      4'd3:    enc = 7'b0110000;
      4'd4:    enc = 7'b0011001;
      4'd5:    enc = 7'b0010010;
      4'd6:    enc = 7'b0000010;
      4'd7:    enc = 7'b1111000;
      4'd8:    enc = 7'b0000000;
      4'd9:    enc = 7'b0010000;
      default: enc = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 6; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Walk from the most significant digit; blanking stops at the first non-zero digit.
  always_comb begin
    seg_next = '1;
    lead     = 1'b1;
    if (ovf_q) begin
      seg_next = {6{7'b0111111}};
    end else begin
      for (int i = 5; i >= 0; i--) begin
        if (BLANK_LEADING && lead && (i != 0) && (bcd_q[4*i +: 4] == 4'd0)) begin
          seg_next[7*i +: 7] = 7'b1111111;
        end else begin
          lead               = 1'b0;
          seg_next[7*i +: 7] = enc(bcd_q[4*i +: 4]);
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    seg_d      = seg_q;
    ovf_out_d  = ovf_out_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          bin_d   = value;
          bcd_d   = '0;
          cnt_d   = '0;
          ovf_d   = 32'(value) > 32'd999999;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj[22:0], bin_q, 1'b0};
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(IN_W - 1)) state_d = UPDATE;
        if (load) begin
          pend_d     = 1'b1;
          pend_val_d = value;
        end
      end
      UPDATE: begin
        seg_d     = seg_next;
        ovf_out_d = ovf_q;
        done_d    = 1'b1;
        pend_d    = 1'b0;
        state_d   = IDLE;
        // A load in this very cycle supersedes any older pending value.
        if (load || pend_q) begin
          bin_d   = load ? value : pend_val_q;
          bcd_d   = '0;
          cnt_d   = '0;
          ovf_d   = 32'(load ? value : pend_val_q) > 32'd999999;
          state_d = SHIFT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      seg_q      <= '1;
      ovf_out_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      seg_q      <= seg_d;
      ovf_out_q  <= ovf_out_d;
      done_q     <= done_d;
    end
  end

  assign {seg5, seg4, seg3, seg2, seg1, seg0} = seg_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign overflow    = ovf_out_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cal_seg_display.sv
// Randomized and directed bench for cal_seg_display; expected displays come from
// decimal arithmetic on the loaded value, with one DUT blanking and one showing all digits.
module tb_cal_seg_display;
  localparam int IN_W = 21;

  logic            clk = 1'b0;
  logic            reset;
  logic            load;
  logic [IN_W-1:0] value;

  logic [6:0] a0, a1, a2, a3, a4, a5, b0, b1, b2, b3, b4, b5;
  logic       busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
  logic [1:0] st_a, st_b;
  logic [41:0] disp_a, disp_b;

  int n_checks = 0;
  int n_fail   = 0;
  logic [IN_W-1:0] exp_q[$];
  logic [41:0] last_disp;

  cal_seg_display #(.IN_W(IN_W), .BLANK_LEADING(1'b1)) dut_a (
    .clk(clk), .reset(reset), .value(value), .load(load),
    .seg0(a0), .seg1(a1), .seg2(a2), .seg3(a3), .seg4(a4), .seg5(a5),
    .busy(busy_a), .done(done_a), .overflow(ovf_a), .dbg_state_o(st_a));

  cal_seg_display #(.IN_W(IN_W), .BLANK_LEADING(1'b0)) dut_b (
    .clk(clk), .reset(reset), .value(value), .load(load),
    .seg0(b0), .seg1(b1), .seg2(b2), .seg3(b3), .seg4(b4), .seg5(b5),
    .busy(busy_b), .done(done_b), .overflow(ovf_b), .dbg_state_o(st_b));

  assign disp_a = {a5, a4, a3, a2, a1, a0};
  assign disp_b = {b5, b4, b3, b2, b1, b0};

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [41:0] model(input int unsigned v, input bit blank);
    logic [6:0] tbl [10];
    int unsigned p;
    int unsigned d;
    logic [41:0] r;
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    if (v > 999999) return {6{7'b0111111}};
    p = 1;
    r = '1;
    for (int i = 0; i < 6; i++) begin
      d = (v / p) % 10;
      if (blank && i > 0 && v < p) r[7*i +: 7] = 7'b1111111;
      else                         r[7*i +: 7] = tbl[d];
      p = p * 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // driver tasks
  task automatic pulse_load(input logic [IN_W-1:0] v);
    @(negedge clk);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic wait_done(input int budget, input logic [41:0] hold, output int lat);
    lat = 0;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk);
      #1;
      if (c == 5) check("hold_segs", 64'(disp_a), 64'(hold));
      if (done_a) begin
        lat = c;
        break;
      end
    end
    if (lat == 0) check("done_timeout", 64'(done_a), 64'd1);
  endtask

  task automatic check_disp(input logic busy_exp);
    logic [IN_W-1:0] v;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 64'(exp_q.size()), 64'd1);
      return;
    end
    v = exp_q.pop_front();
    check("segs_blank", 64'(disp_a), 64'(model(v, 1'b1)));
    check("segs_full", 64'(disp_b), 64'(model(v, 1'b0)));
    check("overflow", 64'(ovf_a), 64'(v > 999999));
    check("overflow_full", 64'(ovf_b), 64'(v > 999999));
    check("done_full", 64'(done_b), 64'd1);
    check("busy_at_done", 64'(busy_a), 64'(busy_exp));
    last_disp = model(v, 1'b1);
  endtask

  task automatic run_one(input logic [IN_W-1:0] v);
    int lat;
    exp_q.push_back(v);
    pulse_load(v);
    wait_done(40, last_disp, lat);
    check("latency", 64'(lat), 64'd22);
    check_disp(1'b0);
    @(posedge clk);
    #1;
    check("done_one_cycle", 64'(done_a), 64'd0);
    check("busy_idle", 64'(busy_a), 64'd0);
  endtask

  initial begin
    int unsigned dir [7];
    int lat;
    int done_cnt;
    dir = '{0, 123456, 905, 1000000, 2097151, 42, 999999};
    reset = 1'b1;
    load  = 1'b0;
    value = '0;
    last_disp = '1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_segs", 64'(disp_a), {22'd0, 42'h3ffffffffff});
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_done", 64'(done_a), 64'd0);
    check("rst_ovf", 64'(ovf_a), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_segs", 64'(disp_a), {22'd0, 42'h3ffffffffff});
    check("idle_busy", 64'(busy_a), 64'd0);

    foreach (dir[i]) run_one(IN_W'(dir[i]));

    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(0, 2))
        0:       run_one(IN_W'($urandom_range(0, 999)));
        1:       run_one(IN_W'($urandom_range(0, 999999)));
        default: run_one(IN_W'($urandom_range(0, 2097151)));
      endcase
    end

    // pending restart: 222 is overwritten by 333 before the restart
    exp_q.push_back(IN_W'(111));
    exp_q.push_back(IN_W'(333));
    pulse_load(IN_W'(111));
    repeat (3) @(negedge clk);
    pulse_load(IN_W'(222));
    repeat (3) @(negedge clk);
    pulse_load(IN_W'(333));
    wait_done(40, last_disp, lat);
    check("pend_first_lat", 64'(lat), 64'd12);
    check_disp(1'b1);
    wait_done(40, last_disp, lat);
    check("pend_second_lat", 64'(lat), 64'd22);
    check_disp(1'b0);
    @(posedge clk);
    #1;
    check("pend_busy_idle", 64'(busy_a), 64'd0);

    // reset mid-conversion with a pending value queued
    pulse_load(IN_W'(555));
    repeat (3) @(negedge clk);
    pulse_load(IN_W'(777));
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("mid_rst_segs", 64'(disp_a), {22'd0, 42'h3ffffffffff});
    check("mid_rst_busy", 64'(busy_a), 64'd0);
    check("mid_rst_done", 64'(done_a), 64'd0);
    check("mid_rst_ovf", 64'(ovf_a), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    last_disp = '1;
    done_cnt = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      if (done_a) done_cnt++;
    end
    check("no_done_after_rst", 64'(done_cnt), 64'd0);
    check("idle_after_rst", 64'(busy_a), 64'd0);
    run_one(IN_W'($urandom_range(0, 999999)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
